// File: rtl/cache_refill_ctrl.sv
// CPU-side controller for a direct-mapped 32-line x 4-word cache: tag/valid lookup,
// in-order 4-word block refill on read miss, write-through with no allocate on writes.
module cache_refill_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINES  = 32,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              busy,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              cache_we,
  output logic              cache_re,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int LINE_W = $clog2(LINES);
  localparam int OFF_W  = ADDR_W - TAG_W - LINE_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, RD_WAIT, REFILL, WR_MEM} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [OFF_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              done_reg, done_next;
  logic [15:0]       hit_cnt_reg, miss_cnt_reg;

  logic [TAG_W-1:0]  req_tag;
  logic [LINE_W-1:0] req_line;
  logic [OFF_W-1:0]  req_off;
  logic [ADDR_W-1:0] fill_addr;
  logic              hit;
  logic              hit_inc, miss_inc, inv_line, fill_line;

  logic [LINES-1:0]  valid_vec;
  logic [TAG_W-1:0]  tag_vec [LINES];

  assign req_tag   = addr_reg[ADDR_W-1 -: TAG_W];
  assign req_line  = addr_reg[OFF_W +: LINE_W];
  assign req_off   = addr_reg[OFF_W-1:0];
  assign fill_addr = {req_tag, req_line, cnt_reg};
  assign hit       = valid_vec[req_line] && (tag_vec[req_line] == req_tag);

  // One valid/tag slot per line; only the slot addressed by the latched request moves.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    logic             valid_reg;
    logic [TAG_W-1:0] tag_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        tag_reg   <= '0;
      end else if (req_line == LINE_W'(gi)) begin
        if (fill_line) begin
          valid_reg <= 1'b1;
          tag_reg   <= req_tag;
        end else if (inv_line) begin
          valid_reg <= 1'b0;
        end
      end
    end

    assign valid_vec[gi] = valid_reg;
    assign tag_vec[gi]   = tag_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      cnt_reg      <= '0;
      rdata_reg    <= '0;
      done_reg     <= 1'b0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      done_reg  <= done_next;
      if (state_reg == IDLE && cpu_req) begin
        addr_reg  <= cpu_addr;
        we_reg    <= cpu_we;
        wdata_reg <= cpu_wdata;
      end
      if (hit_inc && hit_cnt_reg != 16'hFFFF)
        hit_cnt_reg <= hit_cnt_reg + 16'd1;
      if (miss_inc && miss_cnt_reg != 16'hFFFF)
        miss_cnt_reg <= miss_cnt_reg + 16'd1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rdata_next  = rdata_reg;
    done_next   = 1'b0;
    cache_addr  = addr_reg;
    cache_wdata = wdata_reg;
    cache_we    = 1'b0;
    cache_re    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_reg;
    mem_wdata   = wdata_reg;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    inv_line    = 1'b0;
    fill_line   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_req) state_next = LOOKUP;
      end
      LOOKUP: begin
        if (we_reg) begin
          // Write-through, no allocate: only an already-resident line is updated.
          cache_we   = hit;
          state_next = WR_MEM;
        end else if (hit) begin
          cache_re   = 1'b1;
          hit_inc    = 1'b1;
          state_next = RD_WAIT;
        end else begin
          inv_line   = 1'b1;
          cnt_next   = '0;
          miss_inc   = 1'b1;
          state_next = REFILL;
        end
      end
      RD_WAIT: begin
        rdata_next = cache_rdata;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      REFILL: begin
        mem_req    = 1'b1;
        mem_addr   = fill_addr;
        cache_addr = fill_addr;
        if (mem_ack) begin
          cache_we    = 1'b1;
          cache_wdata = mem_rdata;
          cnt_next    = cnt_reg + 1'b1;
          if (cnt_reg == req_off) rdata_next = mem_rdata;
          if (cnt_reg == '1) begin
            fill_line  = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WR_MEM: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg != IDLE);
  assign cpu_rdata = rdata_reg;
  assign cpu_done  = done_reg;
  assign hit_cnt   = hit_cnt_reg;
  assign miss_cnt  = miss_cnt_reg;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: memory/cache-array responders plus a
// reference model built from tag/valid arrays and a golden copy of memory.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_done, busy;
  logic [9:0]  cache_addr;
  logic [31:0] cache_wdata, cache_rdata;
  logic        cache_we, cache_re;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .busy(busy),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_re(cache_re), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Environment: main memory, external cache data array, traffic counters.
  logic [31:0] mem_arr   [1024];
  logic [31:0] cache_arr [128];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          n_mem_rd, n_mem_wr, n_cache_we, n_cache_re;
  logic [9:0]  rd_addrs [$];
  logic [9:0]  last_wr_addr, last_cre_addr;
  logic [31:0] last_wr_data;
  logic        re_pend, stall_prev;
  logic [6:0]  re_idx;
  logic [9:0]  stall_addr;

  // Reference model: golden memory image plus per-line tag/valid.
  logic [31:0] ref_mem   [1024];
  bit          ref_valid [32];
  logic [2:0]  ref_tag   [32];
  int          ref_hits, ref_misses;
  int          txn_no = 0;

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
    end
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  // Memory and cache-array responder; all DUT inputs change on the falling edge.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; cache_rdata = '0;
    re_pend = 1'b0; stall_prev = 1'b0; stall_addr = '0;
    forever begin
      @(negedge clk);
      if (re_pend) begin
        cache_rdata = cache_arr[re_idx];
        re_pend = 1'b0;
      end
      mem_ack = 1'b0;
      if (mem_req && !rst) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          wait_cnt  = 0;
          mem_rdata = mem_arr[mem_addr];
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      #1;
      if (stall_prev && mem_req) check_eq("mem_addr_hold", {22'd0, mem_addr}, {22'd0, stall_addr});
      stall_prev = mem_req && !mem_ack;
      stall_addr = mem_addr;
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          n_mem_wr++;
          mem_arr[mem_addr] = mem_wdata;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
        end else begin
          rd_addrs.push_back(mem_addr);
        end
      end
      if (cache_we) begin
        n_cache_we++;
        cache_arr[cache_addr[6:0]] = cache_wdata;
      end
      if (cache_re) begin
        n_cache_re++;
        re_pend = 1'b1;
        re_idx = cache_addr[6:0];
        last_cre_addr = cache_addr;
      end
    end
  end

  task automatic clear_traffic();
    n_mem_rd = 0; n_mem_wr = 0; n_cache_we = 0; n_cache_re = 0;
    rd_addrs.delete();
  endtask

  // Issue one request (call just after a falling edge) and check it against the model.
  task automatic do_txn(input bit we, input logic [9:0] addr, input logic [31:0] wdata, input int dly);
    int  line;
    int  cyc;
    bit  hit;
    line = int'(addr[6:2]);
    hit = ref_valid[line] && (ref_tag[line] == addr[9:7]);
    ack_delay = dly;
    clear_traffic();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cpu_done || cyc >= 300) begin
        cpu_req = 1'b0;
        break;
      end
      // Junk requests while busy must be ignored.
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 10'($urandom);
      cpu_wdata = $urandom;
    end
    check_eq("cpu_done_seen", {31'd0, cpu_done}, 32'd1);
    n_mem_rd = rd_addrs.size();
    if (!we) begin
      if (hit) begin
        ref_hits = sat_inc(ref_hits);
        check_eq("hit_latency", cyc, 3);
        check_eq("hit_mem_rd", n_mem_rd, 0);
        check_eq("hit_cache_re", n_cache_re, 1);
        check_eq("hit_cache_addr", {22'd0, last_cre_addr}, {22'd0, addr});
      end else begin
        ref_misses = sat_inc(ref_misses);
        ref_valid[line] = 1'b1;
        ref_tag[line] = addr[9:7];
        check_eq("miss_mem_rd", n_mem_rd, 4);
        for (int i = 0; i < 4 && i < rd_addrs.size(); i++)
          check_eq("refill_addr", {22'd0, rd_addrs[i]}, {22'd0, addr[9:2], 2'(i)});
        check_eq("miss_cache_we", n_cache_we, 4);
      end
      check_eq("rd_no_mem_wr", n_mem_wr, 0);
      check_eq("cpu_rdata", cpu_rdata, ref_mem[addr]);
    end else begin
      ref_mem[addr] = wdata;
      check_eq("wr_mem_wr", n_mem_wr, 1);
      check_eq("wr_mem_addr", {22'd0, last_wr_addr}, {22'd0, addr});
      check_eq("wr_mem_data", last_wr_data, wdata);
      check_eq("wr_cache_we", n_cache_we, hit ? 1 : 0);
      check_eq("wr_no_mem_rd", n_mem_rd, 0);
    end
    check_eq("hit_cnt", {16'd0, hit_cnt}, ref_hits);
    check_eq("miss_cnt", {16'd0, miss_cnt}, ref_misses);
    $display("txn %0d %s addr=0x%03h %s cycles=%0d rdata=0x%08h hit_cnt=%0d miss_cnt=%0d",
             txn_no, we ? "WR" : "RD", addr, hit ? "hit" : "miss", cyc, cpu_rdata, hit_cnt, miss_cnt);
    txn_no++;
    @(negedge clk);
    check_eq("done_one_cycle", {31'd0, cpu_done}, 32'd0);
    check_eq("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    for (int i = 0; i < 128; i++) cache_arr[i] = $urandom;
    model_reset();
    clear_traffic();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, cpu_done}, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_strobes", {29'd0, cache_we, cache_re, mem_we}, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    check_eq("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    check_eq("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, hit on the same line, conflict miss, and re-miss.
    do_txn(1'b0, 10'h085, 32'h0, 0);
    do_txn(1'b0, 10'h086, 32'h0, 0);
    do_txn(1'b0, 10'h105, 32'h0, 1);
    do_txn(1'b0, 10'h085, 32'h0, 0);
    // Write hit, write miss, then read both back.
    do_txn(1'b1, 10'h087, 32'hDEADBEEF, 0);
    do_txn(1'b1, 10'h200, 32'h12345678, 2);
    do_txn(1'b0, 10'h087, 32'h0, 0);
    do_txn(1'b0, 10'h200, 32'h0, 0);
    // Long memory stalls.
    do_txn(1'b0, 10'h3F2, 32'h0, 5);
    do_txn(1'b1, 10'h3F1, 32'hCAFEF00D, 5);

    // Reset in the middle of a stalled refill, after the second word.
    ack_delay = 5;
    clear_traffic();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0C1;
    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 0;
    while (rd_addrs.size() < 2 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_mid_words", rd_addrs.size(), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_mid_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 10'h0C1, 32'h0, 0);
    do_txn(1'b0, 10'h085, 32'h0, 0);

    // Randomized traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 60; n++) begin
      logic [9:0] a;
      bit         w;
      a = {3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom)};
      w = ($urandom_range(0, 9) < 3);
      do_txn(w, a, $urandom, $urandom_range(0, 3));
    end

    // Hit counter saturation.
    do_txn(1'b0, 10'h0C1, 32'h0, 0);
    force dut.hit_cnt_reg = 16'hFFFF;
    #1;
    release dut.hit_cnt_reg;
    ref_hits = 65535;
    do_txn(1'b0, 10'h0C2, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
